// File: rtl/serial_uart_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module  : serial_uart_bridge_pkg
// Brief   : Shared UART state encoding and framing constants for the
//           serial_uart_bridge slice.
// Revision: 1.0 - initial release
// ============================================================================
package serial_uart_bridge_pkg;

    // Both the TX and RX engines walk the same four frame phases.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // 50 MHz system clock, 115200 baud.
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    // 8N1 framing.
    localparam int UART_DATA_BITS = 8;
    localparam int UART_BIT_IDX_W = $clog2(UART_DATA_BITS);

endpackage : serial_uart_bridge_pkg
`default_nettype wire

// File: rtl/serial_uart_bridge_if.sv
`default_nettype none
// ============================================================================
// Module  : serial_uart_bridge_if
// Brief   : Processor-side serial-IO handshake between data_memory and the
//           UART bridge. The processor is the master, the bridge the slave.
// Revision: 1.0 - initial release
// ============================================================================
interface serial_uart_bridge_if;

    logic [7:0] proc_tx_data;
    logic       proc_tx_wren;
    logic       proc_tx_rdy;
    logic [7:0] proc_rx_data;
    logic       proc_rx_vld;
    logic       proc_rx_rden;

    modport master (
        output proc_tx_data,
        output proc_tx_wren,
        output proc_rx_rden,
        input  proc_tx_rdy,
        input  proc_rx_data,
        input  proc_rx_vld
    );

    modport slave (
        input  proc_tx_data,
        input  proc_tx_wren,
        input  proc_rx_rden,
        output proc_tx_rdy,
        output proc_rx_data,
        output proc_rx_vld
    );

endinterface : serial_uart_bridge_if
`default_nettype wire

// File: rtl/serial_uart_bridge_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : sync_fifo
// Brief   : Single-clock show-ahead FIFO. Head data is visible the cycle
//           after it is pushed; full/valid flags are registered from the
//           next-state occupancy count.
// Revision: 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] push_data_i,
    input  wire logic             pop_i,
    output logic      [WIDTH-1:0] pop_data_o,
    output logic                  full_o,
    output logic                  valid_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             full_q,   full_d;
    logic             valid_q,  valid_d;

    logic             pop_ok;
    logic             push_ok;

    // A pop on a full FIFO frees the slot the concurrent push lands in.
    assign pop_ok  = pop_i && valid_q;
    assign push_ok = push_i && (!full_q || pop_ok);

    // Pointer/count next state; pointers wrap naturally at a power-of-two depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CW'(DEPTH));
        valid_d = (count_d != '0);
    end

    // Control state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            valid_q  <= valid_d;
        end
    end

    // Storage array; contents need no reset because the head is masked when empty.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign pop_data_o = valid_q ? mem_q[rd_ptr_q] : '0;
    assign full_o     = full_q;
    assign valid_o    = valid_q;

endmodule : sync_fifo
`default_nettype wire

// File: rtl/serial_uart_bridge.sv
`default_nettype none
// ============================================================================
// Module  : serial_uart_bridge
// Brief   : 8N1 UART bridge between the processor serial-IO port and the
//           board pins, with a TX FIFO feeding the serialiser and an RX FIFO
//           presenting received bytes show-ahead.
// Revision: 1.0 - initial release
// ============================================================================
module serial_uart_bridge
    import serial_uart_bridge_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 16
) (
    input  wire logic        clock,
    input  wire logic        reset,
    serial_uart_bridge_if.slave proc_bus,
    input  wire logic        uart_rxd,
    output logic             uart_txd,
    output logic             rx_overrun,
    output logic             rx_frame_err
);

    localparam int                  CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]    CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [UART_BIT_IDX_W-1:0] BIT_LAST = UART_BIT_IDX_W'(UART_DATA_BITS - 1);

    // ------------------------------------------------------------------
    // FIFOs
    // ------------------------------------------------------------------
    logic                      tx_pop;
    logic [UART_DATA_BITS-1:0] tx_head;
    logic                      tx_full;
    logic                      tx_valid;

    logic                      rx_push;
    logic                      rx_full;

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (proc_bus.proc_tx_wren),
        .push_data_i (proc_bus.proc_tx_data),
        .pop_i       (tx_pop),
        .pop_data_o  (tx_head),
        .full_o      (tx_full),
        .valid_o     (tx_valid)
    );

    assign proc_bus.proc_tx_rdy = !tx_full;

    logic [UART_DATA_BITS-1:0] rx_shift_q, rx_shift_d;

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (rx_push),
        .push_data_i (rx_shift_q),
        .pop_i       (proc_bus.proc_rx_rden),
        .pop_data_o  (proc_bus.proc_rx_data),
        .full_o      (rx_full),
        .valid_o     (proc_bus.proc_rx_vld)
    );

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    uart_state_e               tx_state_q, tx_state_d;
    logic [CNT_W-1:0]          tx_cnt_q,   tx_cnt_d;
    logic [UART_BIT_IDX_W-1:0] tx_bit_q,   tx_bit_d;
    logic [UART_DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                      txd_q,      txd_d;

    // TX frame sequencing; a STOP that finds more data goes straight to START.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        tx_pop     = 1'b0;
        unique case (tx_state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
                if (tx_valid) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    txd_d      = 1'b0;
                    tx_cnt_d   = '0;
                    tx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    txd_d      = tx_shift_q[0];
                    tx_state_d = ST_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == BIT_LAST) begin
                        txd_d      = 1'b1;
                        tx_state_d = ST_STOP;
                    end else begin
                        tx_bit_d   = tx_bit_q + UART_BIT_IDX_W'(1);
                        tx_shift_d = tx_shift_q >> 1;
                        txd_d      = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_valid) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_head;
                        txd_d      = 1'b0;
                        tx_state_d = ST_START;
                    end else begin
                        tx_state_d = ST_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
    end

    // TX state register; reset aborts any frame and returns the line high.
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
        end
    end

    assign uart_txd = txd_q;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic                      rx_meta_q;
    logic                      rx_sync_q;
    logic                      rx_prev_q;
    uart_state_e               rx_state_q, rx_state_d;
    logic [CNT_W-1:0]          rx_cnt_q,   rx_cnt_d;
    logic [UART_BIT_IDX_W-1:0] rx_bit_q,   rx_bit_d;
    logic                      overrun_q,  overrun_d;
    logic                      frame_q,    frame_d;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rxd;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // RX frame sequencing; data and stop are sampled a whole bit after the start midpoint.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        overrun_d  = overrun_q;
        frame_d    = frame_q;
        rx_push    = 1'b0;
        unique case (rx_state_q)
            ST_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (rx_cnt_q == CNT_HALF) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    // A line already back high at mid-start was only a glitch.
                    rx_state_d = rx_sync_q ? ST_IDLE : ST_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[UART_DATA_BITS-1:1]};
                    if (rx_bit_q == BIT_LAST) begin
                        rx_state_d = ST_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + UART_BIT_IDX_W'(1);
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = ST_IDLE;
                    if (rx_sync_q) begin
                        // A same-cycle processor pop makes room for this byte.
                        rx_push = 1'b1;
                        if (rx_full && !proc_bus.proc_rx_rden) begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    // RX state register; error flags are sticky until reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            overrun_q  <= 1'b0;
            frame_q    <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            overrun_q  <= overrun_d;
            frame_q    <= frame_d;
        end
    end

    assign rx_overrun   = overrun_q;
    assign rx_frame_err = frame_q;

endmodule : serial_uart_bridge
`default_nettype wire

// File: tb/tb_serial_uart_bridge.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_uart_bridge
// Brief   : Self-checking bench for serial_uart_bridge (8 clocks/bit,
//           4-entry FIFOs) with expected-byte scoreboards for TX and RX.
// Revision: 1.0 - initial release
// ============================================================================
module tb_serial_uart_bridge;

    localparam int CLKS  = 8;
    localparam int DEPTH = 4;

    logic clock;
    logic reset;
    logic uart_rxd;
    logic uart_txd;
    logic rx_overrun;
    logic rx_frame_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] tx_exp_q[$];
    logic [7:0] rx_exp_q[$];

    serial_uart_bridge_if u_if ();

    serial_uart_bridge #(
        .CLKS_PER_BIT (CLKS),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .proc_bus     (u_if.slave),
        .uart_rxd     (uart_rxd),
        .uart_txd     (uart_txd),
        .rx_overrun   (rx_overrun),
        .rx_frame_err (rx_frame_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Capture one frame from uart_txd, sampling mid-bit; returns after the last stop cycle.
    task automatic capture_tx_frame(output logic [7:0] b, output logic stop_bit,
                                    output int gap, output bit ok);
        b = '0; stop_bit = 1'b0; gap = 0; ok = 1'b0;
        @(negedge clock);
        while (uart_txd !== 1'b0 && gap < 400) begin
            @(negedge clock);
            gap++;
        end
        if (uart_txd !== 1'b0) return;
        repeat (CLKS/2) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            repeat (CLKS) @(negedge clock);
            b[i] = uart_txd;
        end
        repeat (CLKS) @(negedge clock);
        stop_bit = uart_txd;
        repeat (CLKS/2 - 1) @(negedge clock);
        ok = 1'b1;
    endtask

    // Drive one 8N1 frame on uart_rxd followed by one idle bit time.
    task automatic send_rx_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        @(posedge clock); #1;
        for (int s = 0; s < 10; s++) begin
            uart_rxd = f[s];
            repeat (CLKS) @(posedge clock);
            #1;
        end
        uart_rxd = 1'b1;
        repeat (CLKS) @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b want 1", uart_txd); end
        checks++; if (u_if.proc_rx_vld !== 1'b0) begin errors++; $display("FAIL reset_rx_vld: got %b want 0", u_if.proc_rx_vld); end
        checks++; if (u_if.proc_tx_rdy !== 1'b1) begin errors++; $display("FAIL reset_tx_rdy: got %b want 1", u_if.proc_tx_rdy); end
        checks++; if (u_if.proc_rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", u_if.proc_rx_data); end
        checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", rx_overrun); end
        checks++; if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", rx_frame_err); end
    endtask

    task automatic test_tx_single;
        logic [7:0] exp_b;
        logic [9:0] f;
        bit         bad;
        @(posedge clock); #1;
        u_if.proc_tx_data = 8'hA5;
        u_if.proc_tx_wren = 1'b1;
        tx_exp_q.push_back(8'hA5);
        @(posedge clock); #1;
        u_if.proc_tx_wren = 1'b0;
        exp_b = tx_exp_q.pop_front();
        f = {1'b1, exp_b, 1'b0};
        @(negedge clock);
        checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL tx_latency_n1: got %b want 1", uart_txd); end
        for (int s = 0; s < 10; s++) begin
            bad = 1'b0;
            repeat (CLKS) begin
                @(negedge clock);
                if (uart_txd !== f[s]) bad = 1'b1;
                if (u_if.proc_tx_rdy !== 1'b1) bad = 1'b1;
            end
            checks++;
            if (bad) begin errors++; $display("FAIL tx_a5_slot%0d: last txd %b want %b (rdy %b)", s, uart_txd, f[s], u_if.proc_tx_rdy); end
        end
        @(negedge clock);
        checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL tx_a5_idle: got %b want 1", uart_txd); end
    endtask

    task automatic test_tx_full;
        logic [7:0] bytes [6];
        logic [7:0] got, exp_b;
        logic       stop_bit;
        int         gap;
        bit         ok, bad;
        bytes = '{8'h3A, 8'hC5, 8'h0F, 8'hF0, 8'h69, 8'h81};
        fork
            begin
                @(negedge clock);
                for (int k = 0; k < 6; k++) begin
                    u_if.proc_tx_data = bytes[k];
                    u_if.proc_tx_wren = 1'b1;
                    // One byte moves into the shifter, DEPTH more fit in the FIFO.
                    if (k < DEPTH + 1) tx_exp_q.push_back(bytes[k]);
                    @(negedge clock);
                    checks++;
                    if (u_if.proc_tx_rdy !== (k < DEPTH)) begin
                        errors++; $display("FAIL tx_full_rdy%0d: got %b want %b", k, u_if.proc_tx_rdy, (k < DEPTH));
                    end
                end
                u_if.proc_tx_wren = 1'b0;
            end
            begin
                for (int fr = 0; fr < 5; fr++) begin
                    capture_tx_frame(got, stop_bit, gap, ok);
                    exp_b = (tx_exp_q.size() > 0) ? tx_exp_q.pop_front() : 8'hXX;
                    checks++;
                    if (!ok || got !== exp_b || stop_bit !== 1'b1) begin
                        errors++; $display("FAIL tx_full_frame%0d: got %h stop %b ok %0d want %h stop 1", fr, got, stop_bit, ok, exp_b);
                    end
                    if (fr > 0) begin
                        checks++;
                        if (gap !== 0) begin errors++; $display("FAIL tx_full_gap%0d: got %0d idle cycles want 0", fr, gap); end
                    end
                end
            end
        join
        bad = 1'b0;
        repeat (15 * CLKS) begin
            @(negedge clock);
            if (uart_txd !== 1'b1) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL tx_full_sixth_dropped: txd went low, want idle high"); end
        checks++; if (u_if.proc_tx_rdy !== 1'b1) begin errors++; $display("FAIL tx_full_rdy_after: got %b want 1", u_if.proc_tx_rdy); end
    endtask

    // Wait for rx_vld (bounded) and compare the head byte against the scoreboard, then pop it.
    task automatic read_rx_byte(input string name);
        logic [7:0] exp_b;
        int         n;
        n = 0;
        @(negedge clock);
        while (u_if.proc_rx_vld !== 1'b1 && n < 4 * CLKS) begin
            @(negedge clock);
            n++;
        end
        exp_b = (rx_exp_q.size() > 0) ? rx_exp_q.pop_front() : 8'hXX;
        checks++;
        if (u_if.proc_rx_vld !== 1'b1 || u_if.proc_rx_data !== exp_b) begin
            errors++; $display("FAIL %s: vld %b data %h want vld 1 data %h", name, u_if.proc_rx_vld, u_if.proc_rx_data, exp_b);
        end
        u_if.proc_rx_rden = 1'b1;
        @(posedge clock); #1;
        u_if.proc_rx_rden = 1'b0;
    endtask

    task automatic test_rx_single;
        rx_exp_q.push_back(8'h3C);
        send_rx_frame(8'h3C, 1'b1);
        read_rx_byte("rx_3c");
        @(negedge clock);
        checks++; if (u_if.proc_rx_vld !== 1'b0) begin errors++; $display("FAIL rx_3c_popped: vld %b want 0", u_if.proc_rx_vld); end
    endtask

    task automatic test_rx_errors;
        @(posedge clock); #1;
        uart_rxd = 1'b0;
        repeat (3) @(posedge clock);
        #1 uart_rxd = 1'b1;
        repeat (12 * CLKS) @(posedge clock);
        @(negedge clock);
        checks++; if (u_if.proc_rx_vld !== 1'b0) begin errors++; $display("FAIL rx_glitch_vld: got %b want 0", u_if.proc_rx_vld); end
        checks++; if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL rx_glitch_ferr: got %b want 0", rx_frame_err); end

        send_rx_frame(8'h55, 1'b0);
        repeat (CLKS) @(negedge clock);
        checks++; if (rx_frame_err !== 1'b1) begin errors++; $display("FAIL rx_frame_err: got %b want 1", rx_frame_err); end
        checks++; if (u_if.proc_rx_vld !== 1'b0) begin errors++; $display("FAIL rx_frame_nopush: vld %b want 0", u_if.proc_rx_vld); end

        for (int k = 0; k < DEPTH; k++) begin
            rx_exp_q.push_back(8'h11 * (k + 1));
            send_rx_frame(8'h11 * (k + 1), 1'b1);
        end
        @(negedge clock);
        checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL rx_overrun_early: got %b want 0", rx_overrun); end
        send_rx_frame(8'hEE, 1'b1);
        @(negedge clock);
        checks++; if (rx_overrun !== 1'b1) begin errors++; $display("FAIL rx_overrun_set: got %b want 1", rx_overrun); end
        for (int k = 0; k < DEPTH; k++) begin
            read_rx_byte($sformatf("rx_overrun_byte%0d", k));
        end
        @(negedge clock);
        checks++; if (u_if.proc_rx_vld !== 1'b0) begin errors++; $display("FAIL rx_overrun_drained: vld %b want 0", u_if.proc_rx_vld); end
        checks++; if (rx_frame_err !== 1'b1) begin errors++; $display("FAIL rx_ferr_sticky: got %b want 1", rx_frame_err); end
    endtask

    task automatic test_reset_mid_tx;
        logic [7:0] got, exp_b;
        logic       stop_bit;
        int         gap, n;
        bit         ok, bad;
        @(posedge clock); #1;
        u_if.proc_tx_data = 8'h96;
        u_if.proc_tx_wren = 1'b1;
        @(posedge clock); #1;
        u_if.proc_tx_data = 8'h0F;
        @(posedge clock); #1;
        u_if.proc_tx_wren = 1'b0;
        n = 0;
        @(negedge clock);
        while (uart_txd !== 1'b0 && n < 20) begin @(negedge clock); n++; end
        // Move into the middle of data bit 3 (0x96 bit 3 is 0).
        repeat (CLKS + 3 * CLKS + CLKS/2) @(negedge clock);
        checks++; if (uart_txd !== 1'b0) begin errors++; $display("FAIL mid_tx_bit3: got %b want 0", uart_txd); end
        #4 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL mid_tx_reset_txd: got %b want 1", uart_txd); end
        checks++; if (u_if.proc_tx_rdy !== 1'b1) begin errors++; $display("FAIL mid_tx_reset_rdy: got %b want 1", u_if.proc_tx_rdy); end
        checks++; if (rx_frame_err !== 1'b0 || rx_overrun !== 1'b0) begin
            errors++; $display("FAIL mid_tx_reset_flags: ferr %b ovr %b want 0 0", rx_frame_err, rx_overrun);
        end
        bad = 1'b0;
        repeat (3 * CLKS) begin
            @(negedge clock);
            if (uart_txd !== 1'b1) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL mid_tx_fifo_cleared: txd low after reset, want idle"); end
        fork
            begin
                @(posedge clock); #1;
                u_if.proc_tx_data = 8'hC3;
                u_if.proc_tx_wren = 1'b1;
                tx_exp_q.push_back(8'hC3);
                @(posedge clock); #1;
                u_if.proc_tx_wren = 1'b0;
            end
            capture_tx_frame(got, stop_bit, gap, ok);
        join
        exp_b = (tx_exp_q.size() > 0) ? tx_exp_q.pop_front() : 8'hXX;
        checks++;
        if (!ok || got !== exp_b || stop_bit !== 1'b1) begin
            errors++; $display("FAIL mid_tx_new_frame: got %h stop %b ok %0d want %h stop 1", got, stop_bit, ok, exp_b);
        end
        bad = 1'b0;
        repeat (12 * CLKS) begin
            @(negedge clock);
            if (uart_txd !== 1'b1) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL mid_tx_no_stale: extra frame after new byte"); end
    endtask

    initial begin
        reset             = 1'b1;
        uart_rxd          = 1'b1;
        u_if.proc_tx_data = 8'h00;
        u_if.proc_tx_wren = 1'b0;
        u_if.proc_rx_rden = 1'b0;
        test_reset();
        test_tx_single();
        test_tx_full();
        test_rx_single();
        test_rx_errors();
        test_reset_mid_tx();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_serial_uart_bridge
`default_nettype wire
